// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle controller and the single-cycle decoder
package mc_ctrl_pkg;
    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_EX  = 4'd2,
        S_MA  = 4'd3,
        S_WB  = 4'd4,
        S_JMP = 4'd5,
        S_ILL = 4'd6
    } state_e;
    typedef enum logic [4:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
        ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV
    } alu_op_e;
    typedef enum logic [3:0] {
        C_R, C_I, C_LD, C_ST, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_JALR, C_ILL
    } cls_e;
    localparam logic [1:0] PC_ALU = 2'd0, PC_BR = 2'd1, PC_J = 2'd2, PC_RS = 2'd3;
    localparam logic [1:0] GPR_RD = 2'd0, GPR_RT = 2'd1, GPR_31 = 2'd2;
    localparam logic [1:0] WD_ALU = 2'd0, WD_MDR = 2'd1, WD_PC = 2'd2;
    localparam logic [1:0] SB_RT = 2'd0, SB_4 = 2'd1, SB_IMM = 2'd2, SB_IMM_SH = 2'd3;
    localparam logic [3:0] LS_LW = 4'd0, LS_LB = 4'd1, LS_LBU = 4'd2, LS_LH = 4'd3, LS_LHU = 4'd4, LS_SB = 4'd5;
endpackage

// File: rtl/mc_ctrl_idec.sv
// mc_idec: combinational opcode/funct decoder giving instruction class and datapath controls
module mc_idec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output cls_e       cls_o,
    output alu_op_e    alu_op_o,
    output logic       ext_op_o,
    output logic [3:0] load_sel_o
);
    // Map each supported opcode/funct to its class and controls; anything else decodes as illegal
    always_comb begin
        cls_o = C_ILL;
        alu_op_o = ALU_NOP;
        ext_op_o = 1'b0;
        load_sel_o = LS_LW;
        case (op_i)
            6'h00: begin
                cls_o = C_R;
                case (funct_i)
                    6'h00: alu_op_o = ALU_SLL;
                    6'h02: alu_op_o = ALU_SRL;
                    6'h03: alu_op_o = ALU_SRA;
                    6'h04: alu_op_o = ALU_SLLV;
                    6'h06: alu_op_o = ALU_SRLV;
                    6'h07: alu_op_o = ALU_SRAV;
                    6'h08: cls_o = C_JR;
                    6'h09: cls_o = C_JALR;
                    6'h20, 6'h21: alu_op_o = ALU_ADD;
                    6'h22, 6'h23: alu_op_o = ALU_SUB;
                    6'h24: alu_op_o = ALU_AND;
                    6'h25: alu_op_o = ALU_OR;
                    6'h26: alu_op_o = ALU_XOR;
                    6'h27: alu_op_o = ALU_NOR;
                    6'h2a: alu_op_o = ALU_SLT;
                    6'h2b: alu_op_o = ALU_SLTU;
                    default: cls_o = C_ILL;
                endcase
            end
            6'h02: cls_o = C_J;
            6'h03: cls_o = C_JAL;
            6'h04: begin cls_o = C_BEQ; alu_op_o = ALU_SUB; ext_op_o = 1'b1; end
            6'h05: begin cls_o = C_BNE; alu_op_o = ALU_SUB; ext_op_o = 1'b1; end
            6'h08, 6'h09: begin cls_o = C_I; alu_op_o = ALU_ADD; ext_op_o = 1'b1; end
            6'h0a: begin cls_o = C_I; alu_op_o = ALU_SLT; ext_op_o = 1'b1; end
            6'h0b: begin cls_o = C_I; alu_op_o = ALU_SLTU; ext_op_o = 1'b1; end
            6'h0c: begin cls_o = C_I; alu_op_o = ALU_AND; end
            6'h0d: begin cls_o = C_I; alu_op_o = ALU_OR; end
            6'h0e: begin cls_o = C_I; alu_op_o = ALU_XOR; end
            6'h20: begin cls_o = C_LD; alu_op_o = ALU_ADD; ext_op_o = 1'b1; load_sel_o = LS_LB; end
            6'h21: begin cls_o = C_LD; alu_op_o = ALU_ADD; ext_op_o = 1'b1; load_sel_o = LS_LH; end
            6'h23: begin cls_o = C_LD; alu_op_o = ALU_ADD; ext_op_o = 1'b1; load_sel_o = LS_LW; end
            6'h24: begin cls_o = C_LD; alu_op_o = ALU_ADD; ext_op_o = 1'b1; load_sel_o = LS_LBU; end
            6'h25: begin cls_o = C_LD; alu_op_o = ALU_ADD; ext_op_o = 1'b1; load_sel_o = LS_LHU; end
            6'h28: begin cls_o = C_ST; alu_op_o = ALU_ADD; ext_op_o = 1'b1; load_sel_o = LS_SB; end
            6'h2b: begin cls_o = C_ST; alu_op_o = ALU_ADD; ext_op_o = 1'b1; load_sel_o = LS_LW; end
            default: ;
        endcase
    end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM (fetch, decode, execute, memory, write-back, jump, illegal)
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       MemReq,
    output logic       MemWE,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSource,
    output logic       RegWrite,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [4:0] ALUOp,
    output logic       EXTOp,
    output logic [3:0] LOADSel,
    output logic       illegal,
    output logic [3:0] state
);
    cls_e       cls;
    alu_op_e    alu_op;
    logic       ext_op;
    logic [3:0] load_sel;
    state_e     state_q;
    logic       illegal_q;
    logic       is_br, is_jmp, is_mem, is_link;

    mc_idec u_idec (
        .op_i      (Op),
        .funct_i   (Funct),
        .cls_o     (cls),
        .alu_op_o  (alu_op),
        .ext_op_o  (ext_op),
        .load_sel_o(load_sel)
    );

    assign is_br   = cls == C_BEQ || cls == C_BNE;
    assign is_jmp  = cls == C_J || cls == C_JAL || cls == C_JR || cls == C_JALR;
    assign is_mem  = cls == C_LD || cls == C_ST;
    assign is_link = cls == C_JAL || cls == C_JALR;
    assign state   = rstn ? state_q : S_IF;
    assign illegal = rstn & illegal_q;

    // State sequencing; ILL is left only through reset, and the sticky flag is set on entry
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IF;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_IF:    state_q <= mem_ready ? S_ID : S_IF;
                S_ID:    state_q <= cls == C_ILL ? S_ILL : is_jmp ? S_JMP : S_EX;
                S_EX:    state_q <= is_br ? S_IF : is_mem ? S_MA : S_WB;
                S_MA:    state_q <= !mem_ready ? S_MA : cls == C_LD ? S_WB : S_IF;
                S_ILL:   state_q <= S_ILL;
                default: state_q <= S_IF;
            endcase
            if (state_q == S_ID && cls == C_ILL) illegal_q <= 1'b1;
        end
    end

    // Moore decode of state and IR; only the fetch writes and branch PCWrite see mem_ready/Zero
    always_comb begin
        MemReq = 1'b0;
        MemWE = 1'b0;
        IorD = 1'b0;
        IRWrite = 1'b0;
        PCWrite = 1'b0;
        PCSource = PC_ALU;
        RegWrite = 1'b0;
        GPRSel = GPR_RD;
        WDSel = WD_ALU;
        ALUSrcA = 1'b0;
        ALUSrcB = SB_RT;
        ALUOp = ALU_NOP;
        EXTOp = 1'b0;
        LOADSel = LS_LW;
        if (rstn) begin
            case (state_q)
                S_IF: begin
                    MemReq = 1'b1;
                    ALUSrcB = SB_4;
                    ALUOp = ALU_ADD;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_ID: begin
                    ALUSrcB = SB_IMM_SH;
                    ALUOp = ALU_ADD;
                    EXTOp = 1'b1;
                end
                S_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = (cls == C_R || is_br) ? SB_RT : SB_IMM;
                    ALUOp = alu_op;
                    EXTOp = ext_op;
                    PCWrite = (cls == C_BEQ && Zero) || (cls == C_BNE && !Zero);
                    PCSource = is_br ? PC_BR : PC_ALU;
                end
                S_MA: begin
                    MemReq = 1'b1;
                    IorD = 1'b1;
                    MemWE = cls == C_ST;
                    LOADSel = load_sel;
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    GPRSel = cls == C_R ? GPR_RD : GPR_RT;
                    WDSel = cls == C_LD ? WD_MDR : WD_ALU;
                end
                S_JMP: begin
                    PCWrite = 1'b1;
                    PCSource = (cls == C_J || cls == C_JAL) ? PC_J : PC_RS;
                    RegWrite = is_link;
                    GPRSel = cls == C_JAL ? GPR_31 : GPR_RD;
                    WDSel = is_link ? WD_PC : WD_ALU;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameters: none; encodings come from the shared package.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 Op  in  6  opcode of the instruction register (IR[31:26]).
REQ-005 Funct  in  6  funct field (IR[5:0]).
REQ-006 Zero  in  1  ALU zero flag, combinational from the current cycle.
REQ-007 mem_ready  in  1  unified memory handshake; access completes on a cycle with MemReq=1 and mem_ready=1.
REQ-008 MemReq  out  1  memory access request, held until mem_ready.
REQ-009 MemWE  out  1  store qualifier, valid only while MemReq=1.
REQ-010 IorD  out  1  address source: 0=PC, 1=ALUOut.
REQ-011 IRWrite  out  1  load IR from memory read data.
REQ-012 PCWrite  out  1  load PC from the PCSource mux.
REQ-013 PCSource  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target, 11=rs.
REQ-014 RegWrite  out  1  register file write strobe.
REQ-015 GPRSel  out  2  destination: 00=rd, 01=rt, 10=$31.
REQ-016 WDSel  out  2  write data: 00=ALUOut, 01=MDR, 10=PC.
REQ-017 ALUSrcA  out  1  0=PC, 1=rs.
REQ-018 ALUSrcB  out  2  00=rt, 01=constant 4, 10=extended immediate, 11=extended immediate shifted left 2.
REQ-019 ALUOp  out  5  ALU operation, package encoding (NOP=0, ADD=1, SUB=2, ... SRAV=14).
REQ-020 EXTOp  out  1  1=sign-extend the immediate.
REQ-021 LOADSel  out  4  load/store width selector (lw=0, lb=1, lbu=2, lh=3, lhu=4, sb=5).
REQ-022 illegal  out  1  sticky unsupported-instruction flag.
REQ-023 state  out  4  current FSM state, for debug.

Function
REQ-024 States: IF=0, ID=1, EX=2, MA=3, WB=4, JMP=5, ILL=6; other encodings go to IF on the next edge.
REQ-025 IF: MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD; stay in IF while mem_ready=0; when mem_ready=1, IRWrite=1, PCWrite=1, PCSource=00, next state ID.
REQ-026 ID: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD, EXTOp=1 (branch target into ALUOut); j/jal/jr/jalr go to JMP, unsupported Op/Funct goes to ILL, otherwise go to EX.
REQ-027 EX: ALUSrcA=1; ALUSrcB=10 for I-type, 00 for R-type; ALUOp and EXTOp per instruction, identical to the single-cycle decode table; beq/bne go to IF; loads/stores go to MA; others go to WB.
REQ-028 EX branch: ALUOp=SUB; PCWrite=(beq&Zero)|(bne&~Zero); PCSource=01.
REQ-029 MA: MemReq=1, IorD=1, MemWE=store, LOADSel per instruction; wait on mem_ready; on completion, load goes to WB and store goes to IF.
REQ-030 WB: RegWrite=1 for exactly one cycle; GPRSel=01 for I-type, 00 for R-type; WDSel=01 for loads, otherwise 00; next state IF.
REQ-031 JMP: PCWrite=1; PCSource=10 for j/jal, 11 for jr/jalr; jal: RegWrite=1, GPRSel=10, WDSel=10; jalr: RegWrite=1, GPRSel=00, WDSel=10; next state IF.
REQ-032 ILL: every strobe is 0 and illegal=1; only reset exits this state.
REQ-033 Unlisted outputs default to 0 in each state; the strobes (PCWrite, IRWrite, RegWrite, MemReq) are never asserted outside the states named above.
REQ-034 Cycles per instruction, with no memory wait: ALU 4, load 5, store 4, branch 3, jump 3; each mem_ready=0 cycle adds 1.
REQ-035 All outputs are Moore decodes of the state and IR, except PCWrite in IF/EX and IRWrite, which also depend on mem_ready/Zero.

Reset
REQ-036 When rstn=0 at an edge: state=IF and illegal=0; this holds in any state, including mid-MA with MemReq=1.
REQ-037 While rstn=0, every output is 0 except state=0.

Structure
REQ-038 The state enum, ALUOp codes, NPC/PCSource, GPRSel, WDSel and LOADSel encodings live in the shared control package, which the single-cycle decoder also uses.
REQ-039 Submodule: one combinational instruction decoder, mc_idec (Op, Funct → instruction class and per-instruction ALUOp/EXTOp/LOADSel); mc_ctrl holds only the FSM.

Verification
REQ-040 Reset, then addi with mem_ready=1: states IF,ID,EX,WB,IF; RegWrite=1 only in cycle 4; GPRSel=01; ALUOp=1.
REQ-041 lw with mem_ready low for 3 cycles in MA: MA lasts 4 cycles; MemReq/IorD held at 1; WDSel=01 in WB.
REQ-042 beq with Zero=1: PCWrite=1, PCSource=01 in EX. With Zero=0: no PCWrite in EX; 3 cycles total.
REQ-043 jal: JMP cycle has PCWrite=1, PCSource=10, RegWrite=1, GPRSel=10, WDSel=10.
REQ-044 Op=6'h3F: ILL reached after ID; illegal stays 1 for 100 cycles; rstn=0 clears it and returns the FSM to IF.
REQ-045 rstn=0 during MA of sw with mem_ready=0: MemReq=0 on the next cycle, state=IF, and MemWE is never asserted after the reset.
